// File: rtl/i2s_rx_if.sv
// Parallel sample bus out of the I2S receiver: per-channel words plus one-cycle strobes.
// The receiver drives it through the master modport; consumers read it through slave.
interface i2s_rx_if #(
   parameter int AUDIO_DW = 8
) ();
   logic [AUDIO_DW-1:0] l_data;
   logic [AUDIO_DW-1:0] r_data;
   logic                l_valid;
   logic                r_valid;
   logic                short_word;

   modport master (
      output l_data,
      output r_data,
      output l_valid,
      output r_valid,
      output short_word
   );

   modport slave (
      input l_data,
      input r_data,
      input l_valid,
      input r_valid,
      input short_word
   );
endinterface

// File: rtl/i2s_rx.sv
// Philips I2S receiver: oversamples SCK/WS/SD on clk_i and publishes left/right words.
// Words longer than AUDIO_DW keep their MSBs; shorter words are left-aligned and flagged.
module i2s_rx #(
   parameter int AUDIO_DW    = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  logic      sck_i,
   input  logic      ws_i,
   input  logic      sd_i,
   i2s_rx_if.master  out_if
);
   localparam int CW = $clog2(AUDIO_DW + 1);
   localparam logic [CW-1:0] DW_C = CW'(AUDIO_DW);

   typedef enum logic {ARM, RUN} state_t;

   state_t                state_q, state_d;
   logic [SYNC_STAGES-1:0] sck_sync_q, ws_sync_q, sd_sync_q;
   logic                  sck_d_q;
   logic                  ws_q, ws_d;
   logic [AUDIO_DW-1:0]   shift_q, shift_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [AUDIO_DW-1:0]   l_data_q, l_data_d, r_data_q, r_data_d;
   logic                  l_valid_q, l_valid_d, r_valid_q, r_valid_d;
   logic                  short_q, short_d;

   logic                  sck_s, ws_s, sd_s, sck_rise, ws_chg;
   logic [AUDIO_DW-1:0]   shift_app, word_pub;
   logic [CW-1:0]         cnt_app;

   assign sck_s    = sck_sync_q[SYNC_STAGES-1];
   assign ws_s     = ws_sync_q[SYNC_STAGES-1];
   assign sd_s     = sd_sync_q[SYNC_STAGES-1];
   assign sck_rise = sck_s & ~sck_d_q;
   assign ws_chg   = ws_s ^ ws_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sck_sync_q <= '0;
         ws_sync_q  <= '0;
         sd_sync_q  <= '0;
         sck_d_q    <= 1'b0;
         state_q    <= ARM;
         ws_q       <= 1'b0;
         shift_q    <= '0;
         cnt_q      <= '0;
         l_data_q   <= '0;
         r_data_q   <= '0;
         l_valid_q  <= 1'b0;
         r_valid_q  <= 1'b0;
         short_q    <= 1'b0;
      end else begin
         sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
         ws_sync_q  <= {ws_sync_q[SYNC_STAGES-2:0], ws_i};
         sd_sync_q  <= {sd_sync_q[SYNC_STAGES-2:0], sd_i};
         sck_d_q    <= sck_s;
         state_q    <= state_d;
         ws_q       <= ws_d;
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         l_data_q   <= l_data_d;
         r_data_q   <= r_data_d;
         l_valid_q  <= l_valid_d;
         r_valid_q  <= r_valid_d;
         short_q    <= short_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      ws_d      = ws_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      l_data_d  = l_data_q;
      r_data_d  = r_data_q;
      l_valid_d = 1'b0;
      r_valid_d = 1'b0;
      short_d   = 1'b0;

      // Saturating append; bits past AUDIO_DW are dropped so the MSBs survive.
      shift_app = shift_q;
      cnt_app   = cnt_q;
      if (cnt_q < DW_C) begin
         shift_app = {shift_q[AUDIO_DW-2:0], sd_s};
         cnt_app   = cnt_q + CW'(1);
      end
      word_pub = shift_app << (DW_C - cnt_app);

      if (sck_rise) begin
         ws_d = ws_s;
         unique case (state_q)
            ARM: begin
               if (ws_chg) begin
                  shift_d = '0;
                  cnt_d   = '0;
                  state_d = RUN;
               end
            end
            RUN: begin
               if (ws_chg) begin
                  // The WS-change slot carries the LSB of the outgoing word.
                  if (ws_q) begin
                     r_data_d  = word_pub;
                     r_valid_d = 1'b1;
                  end else begin
                     l_data_d  = word_pub;
                     l_valid_d = 1'b1;
                  end
                  short_d = (cnt_app < DW_C);
                  shift_d = '0;
                  cnt_d   = '0;
               end else begin
                  shift_d = shift_app;
                  cnt_d   = cnt_app;
               end
            end
            default: state_d = ARM;
         endcase
      end
   end

   assign out_if.l_data     = l_data_q;
   assign out_if.r_data     = r_data_q;
   assign out_if.l_valid    = l_valid_q;
   assign out_if.r_valid    = r_valid_q;
   assign out_if.short_word = short_q;
endmodule

// File: tb/tb_i2s_rx.sv
// Scoreboard bench for i2s_rx: drives Philips frames and checks every published word.
module tb_i2s_rx;
   localparam int DW = 8;
   localparam int SS = 2;

   typedef struct {
      logic          ch;
      logic [DW-1:0] data;
      logic          shrt;
      int            cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_ni = 1'b0;
   logic sck = 1'b0, ws = 1'b0, sd = 1'b0;
   int   cyc = 0;
   int   pass_cnt = 0, total_cnt = 0, pulses = 0;
   logic cur = 1'b0;
   exp_t sb[$];

   i2s_rx_if #(.AUDIO_DW(DW)) rx_if ();

   i2s_rx #(.AUDIO_DW(DW), .SYNC_STAGES(SS)) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .sck_i  (sck),
      .ws_i   (ws),
      .sd_i   (sd),
      .out_if (rx_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: every valid pulse is matched against the scoreboard head.
   always @(negedge clk) begin
      if (rst_ni && (rx_if.l_valid || rx_if.r_valid)) begin
         exp_t e;
         logic [DW-1:0] got;
         pulses++;
         total_cnt++;
         if (rx_if.l_valid && rx_if.r_valid)
            $display("FAIL both_valid: l_valid=%0b r_valid=%0b required one-hot", rx_if.l_valid, rx_if.r_valid);
         else
            pass_cnt++;
         total_cnt++;
         if (sb.size() == 0) begin
            $display("FAIL unexpected_pulse: l_valid=%0b r_valid=%0b at cycle %0d, required none",
                     rx_if.l_valid, rx_if.r_valid, cyc);
         end else begin
            pass_cnt++;
            e = sb.pop_front();
            got = e.ch ? rx_if.r_data : rx_if.l_data;
            total_cnt++;
            if (rx_if.r_valid !== e.ch)
               $display("FAIL channel: got r_valid=%0b required %0b", rx_if.r_valid, e.ch);
            else pass_cnt++;
            total_cnt++;
            if (got !== e.data)
               $display("FAIL data(ch%0b): got 0x%02h required 0x%02h", e.ch, got, e.data);
            else pass_cnt++;
            total_cnt++;
            if (rx_if.short_word !== e.shrt)
               $display("FAIL short: got %0b required %0b", rx_if.short_word, e.shrt);
            else pass_cnt++;
            total_cnt++;
            if (cyc !== e.cyc)
               $display("FAIL latency: pulse at cycle %0d required %0d", cyc, e.cyc);
            else pass_cnt++;
            $display("word ch=%s data=0x%02h short=%0b cycle=%0d", e.ch ? "R" : "L", got, rx_if.short_word, cyc);
         end
      end
   end

   task automatic send_bit(input logic w, input logic d, input logic pub,
                           input logic ch, input logic [DW-1:0] data, input logic shrt);
      exp_t e;
      ws = w;
      sd = d;
      repeat (4) @(negedge clk);
      sck = 1'b1;
      if (pub) begin
         e.ch = ch; e.data = data; e.shrt = shrt; e.cyc = cyc + SS + 1;
         sb.push_back(e);
      end
      repeat (4) @(negedge clk);
      sck = 1'b0;
   endtask

   // One Philips word on channel cur; its last bit is sampled with WS already toggled.
   task automatic send_word(input logic [31:0] val, input int n, input logic pub);
      logic [DW-1:0] expd;
      if (n >= DW) expd = DW'(val >> (n - DW));
      else         expd = DW'(val << (DW - n));
      for (int i = n - 1; i >= 0; i--)
         send_bit((i == 0) ? ~cur : cur, val[i], pub && (i == 0), cur, expd, n < DW);
      cur = ~cur;
   endtask

   task automatic test_reset();
      int p0;
      rst_ni = 1'b0;
      repeat (10) begin
         @(negedge clk);
         sck = 1'($urandom_range(0, 1));
         ws  = 1'($urandom_range(0, 1));
         sd  = 1'($urandom_range(0, 1));
      end
      #1;
      total_cnt++;
      if ({rx_if.l_data, rx_if.r_data} !== '0)
         $display("FAIL reset_data: l=0x%02h r=0x%02h required 0", rx_if.l_data, rx_if.r_data);
      else pass_cnt++;
      total_cnt++;
      if ({rx_if.l_valid, rx_if.r_valid, rx_if.short_word} !== 3'b000)
         $display("FAIL reset_flags: got %b required 000", {rx_if.l_valid, rx_if.r_valid, rx_if.short_word});
      else pass_cnt++;
      @(negedge clk);
      sck = 1'b0; ws = 1'b0; sd = 1'b0;
      repeat (4) @(negedge clk);
      rst_ni = 1'b1;
      p0 = pulses;
      for (int i = 0; i < 6; i++) send_bit(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0, 1'b0);
      repeat (4) @(negedge clk);
      total_cnt++;
      if (pulses !== p0) $display("FAIL reset_no_ws_edge: got %0d pulses required 0", pulses - p0);
      else pass_cnt++;
      $display("test_reset done");
   endtask

   task automatic test_nominal();
      int p0;
      cur = 1'b0;
      send_word(32'hA5, 8, 1'b0);
      p0 = pulses;
      for (int f = 0; f < 3; f++) begin
         send_word(32'h3C, 8, 1'b1);
         send_word(32'hA5, 8, 1'b1);
      end
      total_cnt++;
      if (pulses - p0 !== 6) $display("FAIL nominal_count: got %0d pulses required 6", pulses - p0);
      else pass_cnt++;
      total_cnt++;
      if (sb.size() !== 0) $display("FAIL nominal_drain: got %0d pending required 0", sb.size());
      else pass_cnt++;
      $display("test_nominal done");
   endtask

   task automatic test_long_short();
      send_word(32'h3C, 8, 1'b1);
      send_word(32'hF0F, 12, 1'b1);
      send_word(32'h2D, 6, 1'b1);
      total_cnt++;
      if (sb.size() !== 0) $display("FAIL long_short_drain: got %0d pending required 0", sb.size());
      else pass_cnt++;
      $display("test_long_short done");
   endtask

   task automatic test_reset_midword();
      logic [7:0] v;
      int p0;
      v = 8'h96;
      for (int i = 7; i >= 4; i--) send_bit(cur, v[i], 1'b0, cur, '0, 1'b0);
      @(negedge clk);
      rst_ni = 1'b0;
      #1;
      total_cnt++;
      if ({rx_if.l_data, rx_if.r_data} !== '0)
         $display("FAIL midword_clear: l=0x%02h r=0x%02h required 0", rx_if.l_data, rx_if.r_data);
      else pass_cnt++;
      repeat (3) @(negedge clk);
      rst_ni = 1'b1;
      p0 = pulses;
      for (int i = 3; i >= 0; i--) send_bit((i == 0) ? ~cur : cur, v[i], 1'b0, cur, '0, 1'b0);
      cur = ~cur;
      total_cnt++;
      if (pulses !== p0) $display("FAIL midword_rearm: got %0d pulses required 0", pulses - p0);
      else pass_cnt++;
      send_word(32'h3C, 8, 1'b1);
      total_cnt++;
      if (pulses - p0 !== 1) $display("FAIL midword_first: got %0d pulses required 1", pulses - p0);
      else pass_cnt++;
      $display("test_reset_midword done");
   endtask

   task automatic test_ws_toggle();
      int p0;
      p0 = pulses;
      for (int i = 0; i < 8; i++) send_word(32'($urandom_range(0, 1)), 1, 1'b1);
      total_cnt++;
      if (pulses - p0 !== 8) $display("FAIL toggle_count: got %0d pulses required 8", pulses - p0);
      else pass_cnt++;
      total_cnt++;
      if (sb.size() !== 0) $display("FAIL toggle_drain: got %0d pending required 0", sb.size());
      else pass_cnt++;
      $display("test_ws_toggle done");
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_long_short();
      test_reset_midword();
      test_ws_toggle();
      repeat (10) @(negedge clk);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/i2s_rx.md
# i2s_rx

Receive side of the design's I2S link: recovers left/right audio words from an external SCK/WS/SD stream, using a single system clock. SCK, WS and SD are synchronized and edge-detected; they are not used as clocks. Each completed word is presented as a parallel sample with a one-cycle valid strobe. The block feeds the register-map status bytes, or the audio path, in place of the on-chip noise/KS sources. Its wire format matches the team's `i2s_tx`:
- Philips I2S.
- WS low = left channel.
- MSB first.
- MSB one SCK after the WS change.

## Interface
Parameters:
- AUDIO_DW, 8, output word width in bits.
- SYNC_STAGES, 2, synchronizer flops per input pin (minimum 2).

Ports:
- clk_i  in  1  system clock; all logic on its rising edge.
- rst_ni  in  1  reset. One clock; reset is asynchronous and active-low.
- sck_i  in  1  I2S bit clock, asynchronous to clk_i.
- ws_i  in  1  I2S word select, asynchronous.
- sd_i  in  1  I2S serial data, asynchronous.
- l_data_o  out  AUDIO_DW  last completed left word.
- r_data_o  out  AUDIO_DW  last completed right word.
- l_valid_o  out  1  one-cycle pulse: l_data_o just updated.
- r_valid_o  out  1  one-cycle pulse: r_data_o just updated.
- short_o  out  1  one-cycle pulse, coincident with a valid pulse: that word had fewer than AUDIO_DW bits.

## Operation
Input conditioning:
- sck_i, ws_i and sd_i each pass through SYNC_STAGES flops.
- One further flop on synchronized SCK gives sck_d.
- A rising SCK event (sck_rise) is asserted for exactly one clk_i cycle when synced SCK = 1 and sck_d = 0.
- WS and SD are sampled only in sck_rise cycles, from their synchronized copies.
- ws_q holds the WS value at the previous sck_rise.

Per sck_rise, the bit capture rules are:
- ws_chg = (synced WS != ws_q).
- The SD bit is always appended to the current word: shift left into the MSB end while bit_cnt < AUDIO_DW, then bit_cnt increments.
- Once bit_cnt reaches AUDIO_DW it saturates and further bits are discarded, so long words are truncated and keep their MSBs.
- If ws_chg, the bit sampled in this same sck_rise is the LSB slot of the outgoing word. Append it first, then publish the outgoing word.
- After publishing, clear the shift register and bit_cnt, and set ws_q to the new WS value. The next sck_rise carries the MSB of the new channel.
- If ws_chg is 0, update ws_q to the same value.

Publishing:
- The outgoing channel is ws_q before the update: 0 = left, 1 = right.
- With n = bit_cnt after the append, the published word is the shift register left-aligned, with the low AUDIO_DW−n bits zero-filled.
- short_o = (n < AUDIO_DW).
- Data outputs hold their value between publishes.

State machine, bit_cnt width clog2(AUDIO_DW+1):
- ARM, entered at reset: bits are ignored, nothing is published. The first ws_chg loads ws_q, clears the shift register and bit_cnt, and moves to RUN.
- RUN: the behaviour described above. The first word published is the first complete word after the arming WS edge.
- No other states.

Boundary conditions:
- Exactly AUDIO_DW bits per half-frame (8 SCK at default): the LSB lands in the ws_chg slot; short_o = 0.
- WS toggling on consecutive sck_rise events: publish a 1-bit word (MSB = sd, remaining bits 0) with short_o = 1.
- Reset asserted mid-word: all registers clear immediately and the partial word is lost. After release, return to ARM; no valid pulse until the first complete word after a new WS edge.
- SCK glitch shorter than one clk_i period: undefined. Inputs must meet the Timing constraints.

## Timing
Reset values:
- l_data_o = r_data_o = 0.
- l_valid_o = r_valid_o = short_o = 0.
- State = ARM; ws_q = 0; shift register = 0; bit_cnt = 0.

Latency:
- Let e0 be the clk_i edge that first captures SCK high in sync stage 1.
- Outputs and valid pulses update at edge e0+SYNC_STAGES, i.e. 2 cycles at default.
- Valid pulses last exactly 1 clk_i cycle.

Input requirements:
- sck_i high time and low time are each ≥ SYNC_STAGES+1 clk_i periods.
- WS and SD change on SCK falling edges and are stable ≥ SYNC_STAGES+1 clk_i periods before the SCK rising edge.
- SCK frequency must be ≤ clk_i/(2·(SYNC_STAGES+1)).

Throughput:
- At most one valid pulse per sck_rise.
- l_valid_o and r_valid_o are never high in the same cycle.

## Test plan
- Reset: hold rst_ni=0 with random pins → all outputs 0. Release, then pulse SCK with no WS change → no valid pulses.
- Nominal stream, 8 SCK/half, AUDIO_DW=8, frames L=0xA5 R=0x3C repeated → first pulse is r_valid with r_data=0x3C, short_o=0. Then l_valid with l_data=0xA5 once per frame, each pulse SYNC_STAGES cycles after its sck_i rise.
- Long half-frame of 12 bits 0xF0F on left → l_data=0xF0, short_o=0.
- Short half-frame of 6 bits 101101 on right → r_data=0xB4, short_o=1 together with r_valid.
- Assert rst_ni mid-word at bit 4 → outputs clear at once. After release, first publish occurs only after the full word following a new WS edge.
- WS toggling every SCK → 1-bit words alternate L/R, data=0x80 or 0x00 per sd, short_o=1 on every pulse, never both valids in one cycle.
